pipe_hazard_ctrl: RTL and testbench

//  Central pipeline controller for the FE/DE/AGEX/MEM/WB pipeline.
//  - Detects RAW hazards between the source registers in DE and the destinations in AGEX/MEM/WB.
//  - On a hazard, stalls FE/DE and injects an AGEX bubble.
//  - On a taken branch/jump resolved in AGEX, sequences the PC redirect and the flush of younger stages.
//  - Replaces the ad-hoc per-stage stall wiring between FE, DE and AGEX with a single arbiter.

---
 rtl/pipe_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/redirect controller: RAW stall, AGEX bubble, branch redirect and flush.
// Optional HAZCTRL_PERF_EN macro adds saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int DBITS        = 32,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             de_valid,
    input  logic [4:0]       de_rs1,
    input  logic [4:0]       de_rs2,
    input  logic             de_use_rs1,
    input  logic             de_use_rs2,
    input  logic             agex_valid,
    input  logic             agex_wr_reg,
    input  logic [4:0]       agex_rd,
    input  logic             mem_wr_reg,
    input  logic [4:0]       mem_rd,
    input  logic             wb_wr_reg,
    input  logic [4:0]       wb_rd,
    input  logic             agex_is_branch,
    input  logic             agex_br_taken,
    input  logic [DBITS-1:0] agex_br_target,
    output logic             stall_fe,
    output logic             stall_de,
    output logic             bubble_agex,
    output logic             flush_fe,
    output logic             flush_de,
    output logic             redirect_valid,
    output logic [DBITS-1:0] redirect_pc,
    output logic [1:0]       ctrl_state,
    output logic [15:0]      perf_stalls,
    output logic [15:0]      perf_flushes
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_LOAD =
        (FLUSH_CYCLES > 0) ? 3'(FLUSH_CYCLES - 1) : 3'd0;

    state_t     state;
    logic [2:0] flush_cnt;
    logic       in_run;
    logic       take_br;
    logic       hz_rs1;
    logic       hz_rs2;
    logic       raw_hz;

    assign in_run = (state == RUN);

    // Destination rd==0 never matches; agex only counts when its slot is live.
    assign hz_rs1 = de_use_rs1 && (de_rs1 != 5'd0) && (
        (agex_valid && agex_wr_reg && (agex_rd == de_rs1)) ||
        (mem_wr_reg && (mem_rd == de_rs1)) ||
        (wb_wr_reg && (wb_rd == de_rs1)));
    assign hz_rs2 = de_use_rs2 && (de_rs2 != 5'd0) && (
        (agex_valid && agex_wr_reg && (agex_rd == de_rs2)) ||
        (mem_wr_reg && (mem_rd == de_rs2)) ||
        (wb_wr_reg && (wb_rd == de_rs2)));
    assign raw_hz = de_valid && (hz_rs1 || hz_rs2);

    assign take_br = in_run && agex_valid && agex_is_branch && agex_br_taken;

    // A taken branch beats the stall: the stalled DE op is younger and gets flushed.
    assign stall_de       = raw_hz && in_run && !take_br;
    assign stall_fe       = stall_de;
    assign flush_de       = (state == REDIRECT) || (state == FLUSH);
    assign flush_fe       = flush_de;
    assign bubble_agex    = stall_de || flush_de;
    assign redirect_valid = (state == REDIRECT);
    assign ctrl_state     = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            redirect_pc <= '0;
            flush_cnt   <= 3'd0;
        end else begin
            unique case (state)
                RUN: begin
                    if (take_br) begin
                        state       <= REDIRECT;
                        redirect_pc <= agex_br_target;
                    end
                end
                REDIRECT: begin
                    flush_cnt <= FLUSH_LOAD;
                    state     <= (FLUSH_CYCLES > 0) ? FLUSH : RUN;
                end
                FLUSH: begin
                    if (flush_cnt == 3'd0) begin
                        state <= RUN;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZCTRL_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stalls  <= 16'd0;
            perf_flushes <= 16'd0;
        end else begin
            if (stall_de && (perf_stalls != 16'hFFFF)) begin
                perf_stalls <= perf_stalls + 16'd1;
            end
            if (take_br && (perf_flushes != 16'hFFFF)) begin
                perf_flushes <= perf_flushes + 16'd1;
            end
        end
    end
`else
    assign perf_stalls  = 16'd0;
    assign perf_flushes = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazard vector table plus redirect/flush/reset sequences.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        de_valid;
    logic [4:0]  de_rs1, de_rs2;
    logic        de_use_rs1, de_use_rs2;
    logic        agex_valid, agex_wr_reg;
    logic [4:0]  agex_rd;
    logic        mem_wr_reg;
    logic [4:0]  mem_rd;
    logic        wb_wr_reg;
    logic [4:0]  wb_rd;
    logic        agex_is_branch, agex_br_taken;
    logic [31:0] agex_br_target;
    logic        stall_fe, stall_de, bubble_agex;
    logic        flush_fe, flush_de, redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  ctrl_state;
    logic [15:0] perf_stalls, perf_flushes;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.DBITS(32), .FLUSH_CYCLES(1)) dut (
        .clk(clk), .reset(reset),
        .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
        .de_use_rs1(de_use_rs1), .de_use_rs2(de_use_rs2),
        .agex_valid(agex_valid), .agex_wr_reg(agex_wr_reg), .agex_rd(agex_rd),
        .mem_wr_reg(mem_wr_reg), .mem_rd(mem_rd),
        .wb_wr_reg(wb_wr_reg), .wb_rd(wb_rd),
        .agex_is_branch(agex_is_branch), .agex_br_taken(agex_br_taken),
        .agex_br_target(agex_br_target),
        .stall_fe(stall_fe), .stall_de(stall_de), .bubble_agex(bubble_agex),
        .flush_fe(flush_fe), .flush_de(flush_de),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ctrl_state(ctrl_state),
        .perf_stalls(perf_stalls), .perf_flushes(perf_flushes)
    );

    typedef struct {
        logic       dv;
        logic [4:0] r1, r2;
        logic       u1, u2;
        logic       av, aw;
        logic [4:0] ard;
        logic       mw;
        logic [4:0] mrd;
        logic       ww;
        logic [4:0] wrd;
        logic       exp_stall;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        de_valid = 0; de_rs1 = 0; de_rs2 = 0; de_use_rs1 = 0; de_use_rs2 = 0;
        agex_valid = 0; agex_wr_reg = 0; agex_rd = 0;
        mem_wr_reg = 0; mem_rd = 0; wb_wr_reg = 0; wb_rd = 0;
        agex_is_branch = 0; agex_br_taken = 0; agex_br_target = 0;
    endtask

    task automatic branch(input logic [31:0] tgt);
        agex_valid = 1; agex_is_branch = 1; agex_br_taken = 1;
        agex_br_target = tgt;
    endtask

    task automatic no_branch();
        agex_valid = 0; agex_is_branch = 0; agex_br_taken = 0;
    endtask

    function automatic vec_t mk(
        logic dv, logic [4:0] r1, logic [4:0] r2, logic u1, logic u2,
        logic av, logic aw, logic [4:0] ard, logic mw, logic [4:0] mrd,
        logic ww, logic [4:0] wrd, logic e);
        vec_t v;
        v.dv = dv; v.r1 = r1; v.r2 = r2; v.u1 = u1; v.u2 = u2;
        v.av = av; v.aw = aw; v.ard = ard; v.mw = mw; v.mrd = mrd;
        v.ww = ww; v.wrd = wrd; v.exp_stall = e;
        return v;
    endfunction

    initial begin
        tbl[0] = mk(1, 5, 0, 1, 0, 1, 1, 5, 0, 0, 0, 0, 1);
        tbl[1] = mk(1, 5, 0, 1, 0, 1, 0, 5, 0, 0, 0, 0, 0);
        tbl[2] = mk(1, 0, 0, 1, 1, 1, 1, 0, 1, 0, 1, 0, 0);
        tbl[3] = mk(1, 0, 7, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        tbl[4] = mk(1, 0, 7, 0, 1, 0, 0, 0, 1, 7, 0, 0, 1);
        tbl[5] = mk(1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 1, 9, 1);
        tbl[6] = mk(1, 5, 0, 1, 0, 0, 1, 5, 0, 0, 0, 0, 0);
        tbl[7] = mk(0, 5, 0, 1, 0, 1, 1, 5, 1, 5, 1, 5, 0);
        tbl[8] = mk(1, 1, 3, 1, 1, 1, 1, 3, 0, 0, 0, 0, 1);
        tbl[9] = mk(1, 5, 5, 1, 1, 1, 1, 4, 1, 4, 1, 4, 0);

        idle();
        reset = 1;
        #12;
        check("reset_state", 32'(ctrl_state), 0);
        check("reset_pc", redirect_pc, 0);
        check("reset_rv", 32'(redirect_valid), 0);
        check("reset_flush", 32'({flush_fe, flush_de}), 0);
        check("reset_perf", {perf_stalls, perf_flushes}, 0);
        @(negedge clk);
        reset = 0;

        // Combinational hazard table
        foreach (tbl[i]) begin
            @(negedge clk);
            de_valid = tbl[i].dv; de_rs1 = tbl[i].r1; de_rs2 = tbl[i].r2;
            de_use_rs1 = tbl[i].u1; de_use_rs2 = tbl[i].u2;
            agex_valid = tbl[i].av; agex_wr_reg = tbl[i].aw; agex_rd = tbl[i].ard;
            mem_wr_reg = tbl[i].mw; mem_rd = tbl[i].mrd;
            wb_wr_reg = tbl[i].ww; wb_rd = tbl[i].wrd;
            #1;
            check($sformatf("stall_fe[%0d]", i), 32'(stall_fe), 32'(tbl[i].exp_stall));
            check($sformatf("stall_de[%0d]", i), 32'(stall_de), 32'(tbl[i].exp_stall));
            check($sformatf("bubble[%0d]", i), 32'(bubble_agex), 32'(tbl[i].exp_stall));
        end
        @(negedge clk);
        idle();
        #1;
        check("idle_state", 32'(ctrl_state), 0);

        // Taken branch redirect sequence
        @(negedge clk);
        branch(32'h0000_0100);
        #1;
        check("br_run_rv", 32'(redirect_valid), 0);
        @(negedge clk);
        no_branch();
        #1;
        check("br_redir_rv", 32'(redirect_valid), 1);
        check("br_redir_pc", redirect_pc, 32'h100);
        check("br_redir_st", 32'(ctrl_state), 1);
        check("br_redir_fl", 32'({flush_fe, flush_de}), 3);
        @(negedge clk);
        #1;
        check("br_flush_st", 32'(ctrl_state), 2);
        check("br_flush_fl", 32'({flush_fe, flush_de}), 3);
        check("br_flush_rv", 32'(redirect_valid), 0);
        @(negedge clk);
        #1;
        check("br_back_st", 32'(ctrl_state), 0);
        check("br_back_fl", 32'({flush_fe, flush_de}), 0);

        // Jump and hazard together; branch during FLUSH is ignored
        @(negedge clk);
        de_valid = 1; de_rs1 = 5; de_use_rs1 = 1;
        agex_wr_reg = 1; agex_rd = 5;
        branch(32'h0000_0200);
        #1;
        check("jal_hz_stall", 32'(stall_de), 0);
        check("jal_hz_bub", 32'(bubble_agex), 0);
        @(negedge clk);
        no_branch();
        #1;
        check("jal_redir_st", 32'(ctrl_state), 1);
        check("jal_redir_pc", redirect_pc, 32'h200);
        check("jal_redir_stall", 32'(stall_de), 0);
        check("jal_redir_bub", 32'(bubble_agex), 1);
        @(negedge clk);
        branch(32'h0000_0300);
        #1;
        check("flush_br_st", 32'(ctrl_state), 2);
        @(negedge clk);
        #1;
        check("flush_br_ign", 32'(ctrl_state), 0);
        check("flush_br_pc", redirect_pc, 32'h200);
        idle();
        @(negedge clk);
        #1;
        check("flush_br_stay", 32'(ctrl_state), 0);

        // Reset during FLUSH
        branch(32'h0000_0400);
        @(negedge clk);
        no_branch();
        @(negedge clk);
        #1;
        check("rst_pre_st", 32'(ctrl_state), 2);
        reset = 1;
        #1;
        check("rst_mid_st", 32'(ctrl_state), 0);
        check("rst_mid_fl", 32'({flush_fe, flush_de}), 0);
        check("rst_mid_pc", redirect_pc, 0);
        @(negedge clk);
        reset = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("rst_after_rv%0d", c), 32'(redirect_valid), 0);
        end

        // Perf: 3 stall cycles then 2 taken branches
        @(negedge clk);
        mem_wr_reg = 1; mem_rd = 8; de_valid = 1; de_rs2 = 8; de_use_rs2 = 1;
        repeat (3) @(negedge clk);
        idle();
        for (int b = 0; b < 2; b++) begin
            branch(32'h0000_1000);
            @(negedge clk);
            no_branch();
            repeat (3) @(negedge clk);
        end
        #1;
`ifdef HAZCTRL_PERF_EN
        check("perf_stalls", 32'(perf_stalls), 3);
        check("perf_flushes", 32'(perf_flushes), 2);
`else
        check("perf_stalls", 32'(perf_stalls), 0);
        check("perf_flushes", 32'(perf_flushes), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
